// File: rtl/htif_mem_pkg.sv
// htif_mem_pkg: shared types and width helpers for the HTIF memory port.
// Provides the port FSM state enum and beat/address sizing functions.
package htif_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } htif_state_e;

    function automatic int addr_width(input int num_bytes);
        return $clog2(num_bytes);
    endfunction

    function automatic int mask_width(input int data_width);
        return data_width / 8;
    endfunction

    // Number of low address bits forced to zero for beat alignment.
    function automatic int beat_shift(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    localparam int DEF_BEAT_SHIFT = 3;

endpackage

// File: rtl/htif_resp_reg.sv
// htif_resp_reg: single-entry valid/ready response register.
// Ports: clk, reset, load/load_data (fill), ready (drain), valid/data out.
module htif_resp_reg #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data
);

    // A load wins over a drain so load+consume keeps valid high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/htif_mem_port.sv
// htif_mem_port: host-side burst initiator for the memory's HTIF ports.
// Ports: req_* (burst cmd), wr_* (write beats), resp_* (read beats),
//        busy, hw_* (memory write port), hr_addr/hr_data (read port).
module htif_mem_port
    import htif_mem_pkg::*;
#(
    parameter int NUM_BYTES       = 1 << 21,
    parameter int DATA_WIDTH_HTIF = 64,
    parameter int LEN_WIDTH       = 8,
    localparam int ADDR_WIDTH     = addr_width(NUM_BYTES),
    localparam int MASK_WIDTH     = mask_width(DATA_WIDTH_HTIF)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_rw,
    input  logic [ADDR_WIDTH-1:0]      req_addr,
    input  logic [LEN_WIDTH-1:0]       req_len,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [DATA_WIDTH_HTIF-1:0] wr_data,
    input  logic [MASK_WIDTH-1:0]      wr_mask,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [DATA_WIDTH_HTIF-1:0] resp_data,
    output logic                       busy,
    output logic [ADDR_WIDTH-1:0]      hw_addr,
    output logic [DATA_WIDTH_HTIF-1:0] hw_data,
    output logic [MASK_WIDTH-1:0]      hw_mask,
    output logic                       hw_en,
    output logic [ADDR_WIDTH-1:0]      hr_addr,
    input  logic [DATA_WIDTH_HTIF-1:0] hr_data
);

    localparam int BEAT_BYTES = MASK_WIDTH;
    localparam int SHIFT = beat_shift(DATA_WIDTH_HTIF);

    localparam logic [ADDR_WIDTH-1:0] STEP =
        ADDR_WIDTH'(BEAT_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN =
        ~ADDR_WIDTH'((1 << SHIFT) - 1);

    htif_state_e            state, state_d;
    logic [ADDR_WIDTH-1:0]  cur_addr, addr_d;
    logic [LEN_WIDTH-1:0]   beats_left, left_d;
    logic                   load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cur_addr   <= '0;
            beats_left <= '0;
        end else begin
            state      <= state_d;
            cur_addr   <= addr_d;
            beats_left <= left_d;
        end
    end

    always_comb begin
        state_d   = state;
        addr_d    = cur_addr;
        left_d    = beats_left;
        req_ready = 1'b0;
        wr_ready  = 1'b0;
        hw_en     = 1'b0;
        hw_data   = '0;
        hw_mask   = '0;
        load      = 1'b0;
        unique case (state)
            IDLE: begin
                // Final read beat must drain before a new burst.
                req_ready = !resp_valid;
                if (req_valid && !resp_valid) begin
                    addr_d  = req_addr & ALIGN;
                    left_d  = req_len;
                    state_d = req_rw ? WRITE : READ;
                end
            end
            WRITE: begin
                wr_ready = 1'b1;
                hw_en    = wr_valid;
                hw_data  = wr_data;
                hw_mask  = wr_mask;
            end
            READ: begin
                load = !resp_valid || resp_ready;
            end
            default: state_d = IDLE;
        endcase
        // Shared beat bookkeeping; address wraps modulo NUM_BYTES.
        if (hw_en || load) begin
            addr_d = cur_addr + STEP;
            left_d = beats_left - 1'b1;
            if (beats_left == '0) state_d = IDLE;
        end
    end

    htif_resp_reg #(
        .W(DATA_WIDTH_HTIF)
    ) u_resp (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_data (hr_data),
        .ready     (resp_ready),
        .valid     (resp_valid),
        .data      (resp_data)
    );

    assign hw_addr = cur_addr;
    assign hr_addr = cur_addr;
    assign busy    = (state != IDLE) || resp_valid;

endmodule

// File: doc/htif_mem_port.md
Name: htif_mem_port

Overview:
- Host-side (HTIF) initiator for the byte-addressed async-read memory's HTIF write/read ports.
- Accepts burst read/write requests from the host link over valid/ready channels and drives hw_addr/hw_data/hw_mask/hw_en and hr_addr.
- Samples the combinational hr_data into a registered response channel.
- Sits between the host transport and the memory; used for program load, memory dump and tohost/fromhost polling.

Parameters:
- NUM_BYTES, 1<<21, memory size in bytes; ADDR_WIDTH = $clog2(NUM_BYTES).
- DATA_WIDTH_HTIF, 64, HTIF beat width; MASK_WIDTH = DATA_WIDTH_HTIF/8, BEAT_BYTES = MASK_WIDTH.
- LEN_WIDTH, 8, burst length field width (beats-1).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid&&req_ready
- req_rw  in  1  1 = write burst, 0 = read burst
- req_addr  in  ADDR_WIDTH  start byte address; low log2(BEAT_BYTES) bits ignored (forced 0)
- req_len  in  LEN_WIDTH  beats minus one
- wr_valid  in  1  write beat valid
- wr_ready  out  1  write beat accepted
- wr_data  in  DATA_WIDTH_HTIF  write beat data
- wr_mask  in  MASK_WIDTH  per-byte write enable
- resp_valid  out  1  read beat valid
- resp_ready  in  1  read beat consumed
- resp_data  out  DATA_WIDTH_HTIF  read beat data
- busy  out  1  state != IDLE or resp_valid
- hw_addr  out  ADDR_WIDTH  memory write address
- hw_data  out  DATA_WIDTH_HTIF  memory write data
- hw_mask  out  MASK_WIDTH  memory write byte mask
- hw_en  out  1  memory write enable (memory writes on clk rising edge)
- hr_addr  out  ADDR_WIDTH  memory read address
- hr_data  in  DATA_WIDTH_HTIF  memory read data, combinational from hr_addr

Behaviour:
- Clock is clk. Reset is asynchronous and active-high on reset.
- Reset values:
  - state = IDLE; cur_addr = 0; beats_left = 0.
  - resp_valid = 0; resp_data = 0; busy = 0.
  - hw_en = 0; hw_addr, hw_data, hw_mask, hr_addr all 0.
- Reset mid-burst aborts immediately. No further hw_en pulses occur. A pending response is dropped.
- FSM states: IDLE, WRITE, READ.
- IDLE:
  - req_ready = !resp_valid.
  - On accept: cur_addr <= req_addr with low bits cleared; beats_left <= req_len; go to WRITE if req_rw, else READ.
- WRITE:
  - wr_ready = 1. hw_en = wr_valid (combinational). hw_addr = cur_addr, hw_data = wr_data, hw_mask = wr_mask.
  - Each accepted beat writes one beat in that cycle, then cur_addr += BEAT_BYTES and beats_left -= 1.
  - The beat accepted with beats_left == 0 is the last; next state is IDLE.
  - wr_valid low stalls with no write. wr_mask = 0 is a legal beat that writes nothing.
- READ:
  - hr_addr = cur_addr. A beat loads when !resp_valid || resp_ready.
  - On load: resp_data <= hr_data, resp_valid <= 1, then advance the address and count as in WRITE.
  - The last loaded beat returns state to IDLE. resp_valid stays set until consumed.
- Response register:
  - resp_valid clears on resp_valid && resp_ready with no new load.
  - Load and consume in the same cycle keep resp_valid = 1. Full throughput is 1 beat/cycle.
- Latency:
  - Request accept to first hw_en: 1 cycle, given wr_valid.
  - Request accept to first resp_valid: 2 cycles (enter READ, then register).
- Address arithmetic is modulo NUM_BYTES: a burst crossing the top wraps to 0. beats_left is LEN_WIDTH bits, so the maximum burst is 2^LEN_WIDTH beats.
- In IDLE and READ: hw_en = 0 and wr_ready = 0. In IDLE and WRITE: hr_addr holds cur_addr.
- Outside WRITE: hw_addr, hw_data and hw_mask hold don't-care values, but hw_en must be 0.
- A new request cannot be accepted while the previous read's final response is unconsumed.

Decomposition:
- Shared package htif_mem_pkg:
  - State enum htif_state_e {IDLE, WRITE, READ}.
  - Width helper functions: addr width from NUM_BYTES, mask width from data width.
  - Constant for the beat-address alignment shift.
- One natural sub-module: htif_resp_reg, the single-entry valid/ready output register holding resp_data/resp_valid.

Test Plan:
- Write burst: req addr 0x100, len 1, beats 0x1111_2222_3333_4444 (mask 0xFF) and 0xAAAA…AAAA (mask 0x0F) -> hw_en pulses at hw_addr 0x100 then 0x108 with those masks; back in IDLE after 2 accepted beats.
- Read burst: memory preloaded with the values above, read 0x100 len 1, resp_ready=1 -> resp_valid 2 cycles after accept; data 0x1111_2222_3333_4444, then 0x0000_0000_AAAA_AAAA.
- Backpressure: read len 3 with resp_ready held 0 for 5 cycles -> resp_valid stays high and resp_data stable; no beat is lost; 4 beats delivered in order after release.
- Wrap and alignment: req_addr = NUM_BYTES-8+3, len 1, write -> writes at NUM_BYTES-8, then 0x0.
- Write stall: wr_valid toggled 1,0,0,1 for a len-1 write -> exactly 2 hw_en pulses, none during stall cycles.
- Reset mid-burst: assert reset during beat 2 of a len-7 write -> hw_en drops immediately; all outputs at reset values; req_ready=1 one cycle after deassert.
